// File: rtl/dut_vector_streamer_if.sv
// Word-stream bundle: stimulus words in (s_*), result words out (m_*).
// slave = streamer side, master = environment side.
interface dut_vector_streamer_if #(
    parameter int WORD_W = 16
);
    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [WORD_W-1:0] m_data;
    logic              m_last;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/dut_vector_streamer.sv
// Stream-to-vector stimulus shell around a combinational DUT.
// Optional response signature output enabled by DUT_STREAM_SIG_EN.
module dut_vector_streamer #(
    parameter int IN_W   = 150,
    parameter int OUT_W  = 80,
    parameter int WORD_W = 16,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    dut_vector_streamer_if.slave  bus,
    output logic [IN_W-1:0]       vec_out,
    output logic                  vec_strobe,
    input  logic [OUT_W-1:0]      res_in,
    output logic                  busy,
    output logic [15:0]           vec_count
`ifdef DUT_STREAM_SIG_EN
    ,
    output logic [31:0]           sig_out
`endif
);
    localparam int IN_WORDS  = (IN_W + WORD_W - 1) / WORD_W;
    localparam int OUT_WORDS = (OUT_W + WORD_W - 1) / WORD_W;
    localparam int OUT_PAD   = OUT_WORDS * WORD_W;
    localparam int LO_W      = (IN_WORDS - 1) * WORD_W;
    localparam int LAST_W    = IN_W - LO_W;
    localparam int IW        = $clog2(IN_WORDS + 1);
    localparam int OW        = $clog2(OUT_WORDS + 1);
    localparam int CW        = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_SETTLE,
        S_SEND
    } state_t;

    state_t              r_state;
    logic [IW-1:0]       r_idx;
    logic [OW-1:0]       r_j;
    logic [CW-1:0]       r_cnt;
    logic [LO_W-1:0]     r_shadow;
    logic [OUT_PAD-1:0]  r_res;
    logic [IN_W-1:0]     r_vec;
    logic                r_strobe;
    logic                r_s_ready;
    logic                r_m_valid;
    logic [WORD_W-1:0]   r_m_data;
    logic                r_m_last;
    logic [15:0]         r_count;

    logic                w_acc;
    logic                w_xfer;
    logic [OUT_PAD-1:0]  w_res_pad;
    logic [WORD_W-1:0]   w_nxt;

    assign w_acc     = bus.s_valid & r_s_ready;
    assign w_xfer    = r_m_valid & bus.m_ready;
    assign w_res_pad = OUT_PAD'(res_in);

    always_comb begin
        w_nxt = '0;
        for (int k = 0; k < OUT_WORDS; k++) begin
            if (OW'(k) == r_j + OW'(1)) begin
                w_nxt = r_res[k*WORD_W +: WORD_W];
            end
        end
    end

`ifdef DUT_STREAM_SIG_EN
    localparam int SIG_PAD = ((OUT_W + 31) / 32) * 32;
    logic [SIG_PAD-1:0] w_sig_pad;
    logic [31:0]        w_fold;
    logic [31:0]        r_sig;

    assign w_sig_pad = SIG_PAD'(res_in);

    always_comb begin
        w_fold = '0;
        for (int k = 0; k < SIG_PAD / 32; k++) begin
            w_fold = w_fold ^ w_sig_pad[k*32 +: 32];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= '0;
        end else if (r_state == S_SETTLE && r_cnt == CW'(SETTLE - 1)) begin
            r_sig <= {r_sig[30:0], r_sig[31]} ^ w_fold;
        end
    end

    assign sig_out = r_sig;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_LOAD;
            r_idx     <= '0;
            r_j       <= '0;
            r_cnt     <= '0;
            r_shadow  <= '0;
            r_res     <= '0;
            r_vec     <= '0;
            r_strobe  <= 1'b0;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
            r_count   <= '0;
        end else begin
            r_strobe <= 1'b0;
            unique case (r_state)
                S_LOAD: begin
                    if (w_acc && r_idx == IW'(IN_WORDS - 1)) begin
                        // Final word: its bits at or above IN_W are dropped.
                        r_vec     <= {bus.s_data[LAST_W-1:0], r_shadow};
                        r_strobe  <= 1'b1;
                        r_s_ready <= 1'b0;
                        r_idx     <= '0;
                        r_cnt     <= '0;
                        r_state   <= S_SETTLE;
                    end else if (w_acc) begin
                        for (int k = 0; k < IN_WORDS - 1; k++) begin
                            if (r_idx == IW'(k)) begin
                                r_shadow[k*WORD_W +: WORD_W] <= bus.s_data;
                            end
                        end
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == CW'(SETTLE - 1)) begin
                        r_res     <= w_res_pad;
                        r_m_data  <= w_res_pad[WORD_W-1:0];
                        r_m_last  <= (OUT_WORDS == 1);
                        r_m_valid <= 1'b1;
                        r_j       <= '0;
                        r_state   <= S_SEND;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_SEND: begin
                    if (w_xfer && r_j == OW'(OUT_WORDS - 1)) begin
                        r_m_valid <= 1'b0;
                        r_m_data  <= '0;
                        r_m_last  <= 1'b0;
                        r_count   <= r_count + 16'd1;
                        r_s_ready <= 1'b1;
                        r_state   <= S_LOAD;
                    end else if (w_xfer) begin
                        r_j      <= r_j + OW'(1);
                        r_m_data <= w_nxt;
                        r_m_last <= (r_j + OW'(1) == OW'(OUT_WORDS - 1));
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign bus.s_ready = r_s_ready;
    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = r_m_data;
    assign bus.m_last  = r_m_last;
    assign vec_out     = r_vec;
    assign vec_strobe  = r_strobe;
    assign vec_count   = r_count;
    assign busy        = (r_state != S_LOAD) | (r_idx != '0);
endmodule

// File: doc/dut_vector_streamer.md
Name: dut_vector_streamer

Overview:
- Sequential stimulus/response shell that sits on the other side of a combinational device under test.
- Direction in: deserializes a narrow word stream into one IN_W-bit stimulus vector and drives it onto the DUT input bus.
- Direction out: waits a fixed settle time, captures the OUT_W-bit DUT result and serializes it back out as words.
- Replaces file-based single-vector stimulus with streamed, back-pressured multi-vector runs.

Parameters:
- IN_W, 150, DUT input vector width
- OUT_W, 80, DUT output vector width
- WORD_W, 16, stream word width; IN_WORDS = ceil(IN_W/WORD_W) = 10, OUT_WORDS = ceil(OUT_W/WORD_W) = 5
- SETTLE, 1, cycles from vec_out update to result capture (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- s_valid  in  1  input word valid
- s_ready  out  1  input word accepted when s_valid & s_ready
- s_data  in  WORD_W  stimulus word, least-significant word first
- vec_out  out  IN_W  stimulus vector to DUT
- vec_strobe  out  1  one-cycle pulse, vec_out just updated
- res_in  in  OUT_W  DUT result
- m_valid  out  1  result word valid
- m_ready  in  1  downstream accepts result word
- m_data  out  WORD_W  result word, least-significant word first, zero-padded above OUT_W
- m_last  out  1  marks final result word
- busy  out  1  vector in progress
- vec_count  out  16  completed vectors, wraps 16'hFFFF -> 0

Behaviour:
- Clock and reset: one clock domain. rst is asynchronous and active-high.
- Reset values: state LOAD, word index 0, s_ready=1, vec_out=0, vec_strobe=0, m_valid=0, m_data=0, m_last=0, busy=0, vec_count=0, internal buffers 0.
- States: LOAD -> SETTLE -> SEND -> LOAD.
- LOAD:
  - s_ready=1.
  - Each handshake writes s_data into the shadow buffer at bits [k*WORD_W +: WORD_W].
  - Bits of the final word at or above IN_W are discarded.
  - Gaps in s_valid are allowed; the index holds.
  - On acceptance of word IN_WORDS-1: vec_out <= the full shadow vector on the same edge, and vec_strobe=1 for the following cycle only. s_ready=0 and the next state is SETTLE.
  - vec_out changes only on a completed vector; it holds its value across LOAD, SETTLE and SEND.
- SETTLE:
  - Counter runs SETTLE cycles.
  - res_in is sampled on the edge SETTLE cycles after the edge that updated vec_out, into the result buffer.
  - Next state SEND.
- SEND:
  - m_valid=1 and m_data = result word j; m_last=1 when j = OUT_WORDS-1.
  - j advances on m_valid & m_ready.
  - While m_ready=0, m_data and m_last hold and no word is skipped or duplicated.
  - After the last handshake: m_valid=0, vec_count+1, word index cleared, next state LOAD; s_ready=1 the next cycle.
- No overlap: s_ready=0 throughout SETTLE and SEND. Words offered then are not consumed.
- busy=1 when state != LOAD or word index != 0.
- Reset mid-operation: partial vector and pending result discarded; all outputs return to reset values immediately, without waiting for a clock edge.
- Combinational paths: none from s_valid or m_ready to any output other than state updates.

Optional Feature:
- Macro: DUT_STREAM_SIG_EN
- Defined:
  - Adds output port sig_out[31:0]: response signature, reset to 0.
  - Updated on every result capture: sig <= rotl1(sig) ^ fold.
  - fold = XOR of the OUT_W result zero-padded to a multiple of 32 and split into 32-bit chunks.
  - Lets a long run be compared against a reference with a single word.
- Undefined: port, register and logic absent; all other behaviour identical.

Test Plan:
- Loopback res_in = vec_out[79:0]; stream words 16'h0001..16'h000A, m_ready=1 -> m_data 0001,0002,0003,0004,0005; m_last only on 0005; vec_strobe pulses once; vec_count=1.
- Same stimulus with m_ready=0 for 3 cycles while word 0002 is presented -> m_valid stays 1, m_data holds 0002, then 0003..0005 with no duplicates; vec_count=1.
- Idle cycles between input words, and s_valid held high through SETTLE/SEND -> result identical; s_ready=0 during SETTLE/SEND; extra words are consumed only as the next vector.
- Final input word 16'hFFFF with all other words 0 -> vec_out[149:144]=6'h3F, vec_out[143:0]=0; discarded bits have no effect.
- Assert rst after 4 words accepted -> vec_out=0, busy=0, s_ready=1 asynchronously; a following full 10-word vector completes normally with vec_count=1.
- DUT_STREAM_SIG_EN, loopback of vector 1 (result 80'h0005_0004_0003_0002_0001) -> sig_out=32'h00060007 after capture.
